// File: rtl/hazard_scoreboard.sv
// Pipeline hazard unit with MC register scoreboard: forwards, stalls and flushes are combinational (0-cycle).
// Scoreboard/hold state updates on CLK; Busy freezes F/D/E and pauses the load-use hold count.
module hazard_scoreboard #(
    parameter int REG_AW   = 5,
    parameter int LOAD_LAT = 1,
    parameter int MC_DEPTH = 2
) (
    input  logic                              CLK,
    input  logic                              RESET,
    input  logic [REG_AW-1:0]                 rs1D,
    input  logic [REG_AW-1:0]                 rs2D,
    input  logic [REG_AW-1:0]                 rdD,
    input  logic [6:0]                        OpcodeD,
    input  logic                              McOpD,
    input  logic [REG_AW-1:0]                 rs1E,
    input  logic [REG_AW-1:0]                 rs2E,
    input  logic [REG_AW-1:0]                 rdE,
    input  logic [REG_AW-1:0]                 rs2M,
    input  logic [REG_AW-1:0]                 rdM,
    input  logic [REG_AW-1:0]                 rdW,
    input  logic                              RegWriteM,
    input  logic                              RegWriteW,
    input  logic                              MemWriteM,
    input  logic                              MemtoRegE,
    input  logic                              MemtoRegW,
    input  logic                              McStartE,
    input  logic                              McDoneW,
    input  logic [REG_AW-1:0]                 McRdW,
    input  logic                              Busy,
    input  logic [1:0]                        PCSrcE,
    output logic [1:0]                        ForwardAE,
    output logic [1:0]                        ForwardBE,
    output logic                              ForwardM,
    output logic                              Forward1D,
    output logic                              Forward2D,
    output logic                              lwStall,
    output logic                              ldHold,
    output logic                              mcStall,
    output logic                              StallF,
    output logic                              StallD,
    output logic                              StallE,
    output logic                              FlushD,
    output logic                              FlushE,
    output logic [$clog2(MC_DEPTH+1)-1:0]     McCount,
    output logic                              McFull
);
    localparam int NREG = 2**REG_AW;
    localparam int CW   = $clog2(MC_DEPTH+1);
    localparam int PW   = (MC_DEPTH > 1) ? $clog2(MC_DEPTH) : 1;
    localparam int HW   = (LOAD_LAT > 1) ? $clog2(LOAD_LAT) : 1;
    localparam logic [CW:0] DEPTH_X = (CW+1)'(MC_DEPTH);

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_ST    = 7'b0100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    logic              rs1_active, rs2_active, rd_active;
    logic [NREG-1:0]   pend, pend_eff, issue_mask, clr_mask;
    logic [REG_AW-1:0] fifo_mem [MC_DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     mc_count;
    logic [CW:0]       mc_sum;
    logic [HW-1:0]     hold_cnt;
    logic              issue, pop;
    logic              unused_pcsrc;
    // Only read by the completion-order check below.
    logic [REG_AW-1:0] mc_head_unused;

    assign unused_pcsrc   = PCSrcE[1];
    assign mc_head_unused = fifo_mem[rd_ptr];

    assign rs1_active = !(OpcodeD == OP_JAL || OpcodeD == OP_LUI || OpcodeD == OP_AUIPC);
    assign rs2_active = (OpcodeD == OP_R) || (OpcodeD == OP_BR);
    assign rd_active  = !(OpcodeD == OP_ST || OpcodeD == OP_BR);

    always_comb begin
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        if (rs1E == rdM && RegWriteM && rdM != '0)      ForwardAE = 2'b10;
        else if (rs1E == rdW && RegWriteW && rdW != '0) ForwardAE = 2'b01;
        if (rs2E == rdM && RegWriteM && rdM != '0)      ForwardBE = 2'b10;
        else if (rs2E == rdW && RegWriteW && rdW != '0) ForwardBE = 2'b01;
    end

    assign ForwardM  = (rs2M == rdW) && MemWriteM && MemtoRegW && (rdW != '0);
    assign Forward1D = (rs1D == rdW) && RegWriteW && (rdW != '0);
    assign Forward2D = (rs2D == rdW) && RegWriteW && (rdW != '0);

    assign lwStall = MemtoRegE && (rdE != '0) &&
                     ((rs1D == rdE && rs1_active) || (rs2D == rdE && rs2_active));
    assign ldHold  = (hold_cnt != '0);

    assign issue = McStartE && !StallE;
    assign pop   = McDoneW && (mc_count != '0);

    // Register 0 is never marked pending, but its issue still occupies a FIFO slot.
    always_comb begin
        issue_mask = '0;
        clr_mask   = '0;
        if (issue && rdE != '0) issue_mask[rdE]   = 1'b1;
        if (pop)                clr_mask[McRdW]  = 1'b1;
    end

    assign pend_eff = pend | issue_mask;
    assign mc_sum   = {1'b0, mc_count} + {{CW{1'b0}}, issue};

    assign mcStall = (rs1_active && pend_eff[rs1D]) ||
                     (rs2_active && pend_eff[rs2D]) ||
                     (rd_active && rdD != '0 && pend_eff[rdD]) ||
                     (McOpD && mc_sum >= DEPTH_X);

    assign StallF  = lwStall || ldHold || mcStall || Busy;
    assign StallD  = StallF;
    assign StallE  = Busy;
    assign FlushE  = (PCSrcE[0] || lwStall || ldHold || mcStall) && !Busy;
    assign FlushD  = PCSrcE[0] && !Busy;
    assign McCount = mc_count;
    assign McFull  = (mc_count == CW'(MC_DEPTH));

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(MC_DEPTH-1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge CLK) begin
        if (RESET) begin
            pend     <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            mc_count <= '0;
            hold_cnt <= '0;
        end else begin
            // Set wins over clear when issue and completion name the same register.
            pend <= (pend & ~clr_mask) | issue_mask;
            if (issue) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)   rd_ptr <= ptr_inc(rd_ptr);
            if (issue && !pop)      mc_count <= mc_count + CW'(1);
            else if (!issue && pop) mc_count <= mc_count - CW'(1);

            if (FlushD) begin
                hold_cnt <= '0;
            end else if (!Busy) begin
                if (lwStall)              hold_cnt <= HW'(LOAD_LAT-1);
                else if (hold_cnt != '0)  hold_cnt <= hold_cnt - HW'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (issue) fifo_mem[wr_ptr] <= rdE;
    end

    mc_done_order: assert property (@(posedge CLK) disable iff (RESET)
        pop |-> (McRdW == mc_head_unused));
    mc_issue_room: assert property (@(posedge CLK) disable iff (RESET)
        issue |-> !McFull);

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard (LOAD_LAT=3, MC_DEPTH=2): vector table plus clocked sequences.
`timescale 1ns/1ps
module tb_hazard_scoreboard;
    localparam int REG_AW   = 5;
    localparam int LOAD_LAT = 3;
    localparam int MC_DEPTH = 2;
    localparam int CW       = $clog2(MC_DEPTH+1);

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_LUI = 7'b0110111;

    logic CLK = 1'b0;
    logic RESET;
    logic [REG_AW-1:0] rs1D, rs2D, rdD, rs1E, rs2E, rdE, rs2M, rdM, rdW, McRdW;
    logic [6:0] OpcodeD;
    logic McOpD, RegWriteM, RegWriteW, MemWriteM, MemtoRegE, MemtoRegW;
    logic McStartE, McDoneW, Busy;
    logic [1:0] PCSrcE;
    logic [1:0] ForwardAE, ForwardBE;
    logic ForwardM, Forward1D, Forward2D, lwStall, ldHold, mcStall;
    logic StallF, StallD, StallE, FlushD, FlushE, McFull;
    logic [CW-1:0] McCount;

    int vectors    = 0;
    int miscompares = 0;

    always #5 CLK = ~CLK;

    hazard_scoreboard #(.REG_AW(REG_AW), .LOAD_LAT(LOAD_LAT), .MC_DEPTH(MC_DEPTH)) u_dut (
        .CLK(CLK), .RESET(RESET),
        .rs1D(rs1D), .rs2D(rs2D), .rdD(rdD), .OpcodeD(OpcodeD), .McOpD(McOpD),
        .rs1E(rs1E), .rs2E(rs2E), .rdE(rdE), .rs2M(rs2M), .rdM(rdM), .rdW(rdW),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemWriteM(MemWriteM),
        .MemtoRegE(MemtoRegE), .MemtoRegW(MemtoRegW),
        .McStartE(McStartE), .McDoneW(McDoneW), .McRdW(McRdW),
        .Busy(Busy), .PCSrcE(PCSrcE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ForwardM(ForwardM),
        .Forward1D(Forward1D), .Forward2D(Forward2D),
        .lwStall(lwStall), .ldHold(ldHold), .mcStall(mcStall),
        .StallF(StallF), .StallD(StallD), .StallE(StallE),
        .FlushD(FlushD), .FlushE(FlushE), .McCount(McCount), .McFull(McFull)
    );

    typedef struct {
        logic [6:0] op;
        logic [4:0] rs1d, rs2d, rdd, rs1e, rs2e, rde, rs2m, rdm, rdw;
        logic       rwm, rww, mwm, mte, mtw;
        logic [1:0] fae, fbe;
        logic       fm, f1d, f2d, lw;
    } vec_t;

    vec_t vecs [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic clr_inputs();
        rs1D = '0; rs2D = '0; rdD = '0; OpcodeD = '0; McOpD = 1'b0;
        rs1E = '0; rs2E = '0; rdE = '0; rs2M = '0; rdM = '0; rdW = '0;
        RegWriteM = 1'b0; RegWriteW = 1'b0; MemWriteM = 1'b0;
        MemtoRegE = 1'b0; MemtoRegW = 1'b0;
        McStartE = 1'b0; McDoneW = 1'b0; McRdW = '0; Busy = 1'b0; PCSrcE = 2'b00;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // One load in E at cycle 0 against a dependent add in D; E holds bubbles afterwards.
    task automatic run_load(input logic [7:0] busy_mask, output int stall_cycles);
        stall_cycles = 0;
        for (int c = 0; c < 8; c++) begin
            OpcodeD = OP_R; rs1D = 5'd5; rs2D = 5'd7; rdD = 5'd6;
            MemtoRegE = (c == 0);
            rdE = (c == 0) ? 5'd5 : 5'd0;
            Busy = busy_mask[c];
            #1;
            if (StallD) stall_cycles++;
            if (Busy) check("flushe_during_busy", FlushE, 0);
            tick();
        end
        clr_inputs();
    endtask

    initial begin
        int n;
        vecs[0]  = '{7'd0,  0,0,0, 0,0,0, 0,0,0, 0,0,0,0,0, 2'b00,2'b00, 0,0,0,0};
        vecs[1]  = '{OP_R,  0,0,0, 5,0,0, 0,5,0, 1,0,0,0,0, 2'b10,2'b00, 0,0,0,0};
        vecs[2]  = '{OP_R,  0,0,0, 0,6,0, 0,0,6, 0,1,0,0,0, 2'b00,2'b01, 0,0,0,0};
        vecs[3]  = '{OP_R,  0,0,0, 7,7,0, 0,7,7, 1,1,0,0,0, 2'b10,2'b10, 0,0,0,0};
        vecs[4]  = '{OP_R,  0,0,0, 7,0,0, 0,7,7, 0,1,0,0,0, 2'b01,2'b00, 0,0,0,0};
        vecs[5]  = '{OP_R,  0,0,0, 0,0,0, 0,0,0, 1,1,1,0,1, 2'b00,2'b00, 0,0,0,0};
        vecs[6]  = '{OP_R,  0,0,0, 0,0,0, 3,0,3, 0,0,1,0,1, 2'b00,2'b00, 1,0,0,0};
        vecs[7]  = '{OP_R,  0,0,0, 0,0,0, 3,0,3, 0,0,1,0,0, 2'b00,2'b00, 0,0,0,0};
        vecs[8]  = '{OP_R,  9,9,0, 0,0,0, 0,0,9, 0,1,0,0,0, 2'b00,2'b00, 0,1,1,0};
        vecs[9]  = '{OP_R,  5,7,6, 0,0,5, 0,0,0, 0,0,0,1,0, 2'b00,2'b00, 0,0,0,1};
        vecs[10] = '{OP_R,  1,5,6, 0,0,5, 0,0,0, 0,0,0,1,0, 2'b00,2'b00, 0,0,0,1};
        vecs[11] = '{OP_I,  1,5,6, 0,0,5, 0,0,0, 0,0,0,1,0, 2'b00,2'b00, 0,0,0,0};
        vecs[12] = '{OP_LUI,5,0,6, 0,0,5, 0,0,0, 0,0,0,1,0, 2'b00,2'b00, 0,0,0,0};
        vecs[13] = '{OP_R,  0,0,6, 0,0,0, 0,0,0, 0,0,0,1,0, 2'b00,2'b00, 0,0,0,0};
        vecs[14] = '{OP_ST, 1,5,0, 0,0,5, 0,0,0, 0,0,0,1,0, 2'b00,2'b00, 0,0,0,0};
        vecs[15] = '{OP_BR, 1,5,0, 0,0,5, 0,0,0, 0,0,0,1,0, 2'b00,2'b00, 0,0,0,1};

        clr_inputs();
        RESET = 1'b1;
        tick(); tick();
        RESET = 1'b0;
        #1;
        check("rst_mccount", McCount, 0);
        check("rst_mcfull",  McFull, 0);
        check("rst_ldhold",  ldHold, 0);
        check("rst_mcstall", mcStall, 0);
        check("rst_stallf",  StallF, 0);
        check("rst_stalle",  StallE, 0);
        check("rst_flushd",  FlushD, 0);

        // Combinational table; reset between vectors so load-use vectors leave no hold behind.
        for (int i = 0; i < 16; i++) begin
            OpcodeD = vecs[i].op; rs1D = vecs[i].rs1d; rs2D = vecs[i].rs2d; rdD = vecs[i].rdd;
            rs1E = vecs[i].rs1e; rs2E = vecs[i].rs2e; rdE = vecs[i].rde;
            rs2M = vecs[i].rs2m; rdM = vecs[i].rdm; rdW = vecs[i].rdw;
            RegWriteM = vecs[i].rwm; RegWriteW = vecs[i].rww; MemWriteM = vecs[i].mwm;
            MemtoRegE = vecs[i].mte; MemtoRegW = vecs[i].mtw;
            #1;
            check($sformatf("v%0d_fae", i), ForwardAE, vecs[i].fae);
            check($sformatf("v%0d_fbe", i), ForwardBE, vecs[i].fbe);
            check($sformatf("v%0d_fm",  i), ForwardM,  vecs[i].fm);
            check($sformatf("v%0d_f1d", i), Forward1D, vecs[i].f1d);
            check($sformatf("v%0d_f2d", i), Forward2D, vecs[i].f2d);
            check($sformatf("v%0d_lw",  i), lwStall,   vecs[i].lw);
            check($sformatf("v%0d_stalld", i), StallD, vecs[i].lw);
            check($sformatf("v%0d_flushe", i), FlushE, vecs[i].lw);
            clr_inputs();
            RESET = 1'b1;
            tick();
            RESET = 1'b0;
        end

        run_load(8'b0000_0000, n);
        check("load_stall_cycles", n, LOAD_LAT);
        run_load(8'b0000_0110, n);
        check("load_busy_stall_cycles", n, LOAD_LAT + 2);

        // Redirect during hold clears the counter.
        OpcodeD = OP_R; rs1D = 5'd5; rdE = 5'd5; MemtoRegE = 1'b1;
        #1; check("redir_lw", lwStall, 1);
        tick();
        MemtoRegE = 1'b0; rdE = '0; PCSrcE = 2'b01;
        #1;
        check("redir_hold", ldHold, 1);
        check("redir_flushd", FlushD, 1);
        check("redir_flushe", FlushE, 1);
        tick();
        PCSrcE = 2'b00;
        #1;
        check("redir_hold_cleared", ldHold, 0);
        check("redir_stalld", StallD, 0);
        clr_inputs();
        tick();

        // Scoreboard: div x8, mul x9, then a third MC op and dependents.
        McStartE = 1'b1; rdE = 5'd8;
        #1; check("sb_cnt0", McCount, 0);
        tick();
        check("sb_cnt1", McCount, 1);
        rdE = 5'd9; McOpD = 1'b1;
        #1; check("sb_opd_with_issue", mcStall, 1);
        tick();
        McStartE = 1'b0; rdE = '0;
        #1;
        check("sb_cnt2", McCount, 2);
        check("sb_full", McFull, 1);
        check("sb_opd_full", mcStall, 1);
        check("sb_flushe", FlushE, 1);
        McOpD = 1'b0; OpcodeD = OP_R; rs1D = 5'd8; rs2D = 5'd1; rdD = 5'd10;
        #1; check("sb_raw_x8", mcStall, 1);
        OpcodeD = OP_ST; rs1D = 5'd1; rs2D = 5'd8; rdD = 5'd8;
        #1; check("sb_sw_rs2", mcStall, 0);
        OpcodeD = OP_I; rs1D = 5'd1; rs2D = 5'd0; rdD = 5'd9;
        #1; check("sb_waw_x9", mcStall, 1);
        OpcodeD = OP_R; rs1D = 5'd8; rs2D = 5'd1; rdD = 5'd10;
        McDoneW = 1'b1; McRdW = 5'd8; RegWriteW = 1'b1; rdW = 5'd8;
        #1;
        check("sb_done_cycle", mcStall, 1);
        check("sb_done_fwd1d", Forward1D, 1);
        tick();
        McDoneW = 1'b0; RegWriteW = 1'b0; rdW = '0; McOpD = 1'b1;
        #1;
        check("sb_clear_next", mcStall, 0);
        check("sb_cnt_after_done", McCount, 1);
        check("sb_notfull", McFull, 0);
        McOpD = 1'b0; McDoneW = 1'b1; McRdW = 5'd9;
        tick();
        McDoneW = 1'b0;
        #1; check("sb_drained", McCount, 0);
        clr_inputs();

        // Same-cycle issue and completion of x4, then an x0 issue.
        McStartE = 1'b1; rdE = 5'd4;
        tick();
        McDoneW = 1'b1; McRdW = 5'd4;
        tick();
        McDoneW = 1'b0; McStartE = 1'b0; rdE = '0; OpcodeD = OP_R; rs1D = 5'd4;
        #1;
        check("same_cnt", McCount, 1);
        check("same_set_wins", mcStall, 1);
        McStartE = 1'b1; rdE = '0; OpcodeD = OP_I; rs1D = '0; rdD = '0;
        #1; check("x0_issue_nopend", mcStall, 0);
        tick();
        McStartE = 1'b0; OpcodeD = OP_R; rs1D = 5'd4;
        #1;
        check("x0_cnt", McCount, 2);
        check("x0_full", McFull, 1);
        check("x4_still_pend", mcStall, 1);

        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        #1;
        check("rst_mid_cnt", McCount, 0);
        check("rst_mid_full", McFull, 0);
        check("rst_mid_pend", mcStall, 0);
        clr_inputs();

        // Completion with an empty FIFO is ignored.
        McDoneW = 1'b1; McRdW = 5'd3;
        tick();
        McDoneW = 1'b0;
        #1;
        check("empty_done_cnt", McCount, 0);
        check("empty_done_full", McFull, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
